// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment path: width codes (shared with the
// load reduce path), the store FSM state type and a width-code decoder.
package store_align_unit_pkg;

    localparam logic [2:0] WIDTH_WORD  = 3'b000;
    localparam logic [2:0] WIDTH_HALF  = 3'b010;
    localparam logic [2:0] WIDTH_HALFU = 3'b110;
    localparam logic [2:0] WIDTH_BYTE  = 3'b001;
    localparam logic [2:0] WIDTH_BYTEU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    // Returns {legal, mask}. Signed/unsigned variants are equivalent for stores.
    function automatic logic [4:0] width_decode(input logic [2:0] width);
        logic [4:0] dec;
        case (width)
            WIDTH_WORD:              dec = 5'b1_1111;
            WIDTH_HALF, WIDTH_HALFU: dec = 5'b1_0011;
            WIDTH_BYTE, WIDTH_BYTEU: dec = 5'b1_0001;
            default:                 dec = 5'b0_0000;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane math for a store: places register data into byte lanes
// across two consecutive words and flags boundary crossings and bad widths.
module store_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  width,
    input  logic [31:0] data,
    output logic [63:0] d64,
    output logic [7:0]  be8,
    output logic        split,
    output logic        illegal
);

    logic [4:0] dec;

    always_comb begin
        dec     = width_decode(width);
        illegal = !dec[4];
        be8     = {4'b0000, dec[3:0]} << off;
        d64     = {32'b0, data} << {off, 3'b000};
        split   = |be8[7:4];
    end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts a store request, shifts it into byte lanes and
// issues one or two word-aligned write beats to the data memory port.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StoreValid,
    output logic        StoreReady,
    input  logic [31:0] StoreAddr,
    input  logic [31:0] StoreData,
    input  logic [2:0]  WidthSrc,
    output logic        MemWriteValid,
    input  logic        MemWriteReady,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic [3:0]  MemByteEn,
    output logic        StoreErr,
    output logic        Busy
);

    // Handshakes: a request is taken when StoreValid && StoreReady on a rising
    // edge; a beat moves when MemWriteValid && MemWriteReady. A presented beat
    // keeps its address/data/enables unchanged until it moves.

    state_t      state;
    logic [63:0] d64;
    logic [7:0]  be8;
    logic        split;
    logic        illegal;
    logic [31:0] word_addr;
    logic [31:0] beat1_addr;
    logic [31:0] beat1_data;
    logic [3:0]  beat1_be;
    logic        split_r;
    logic        xfer;
    logic        final_beat;
    logic        accept;
    logic        drop;

    store_lane_shift u_lane_shift (
        .off     (StoreAddr[1:0]),
        .width   (WidthSrc),
        .data    (StoreData),
        .d64     (d64),
        .be8     (be8),
        .split   (split),
        .illegal (illegal)
    );

    assign word_addr  = {StoreAddr[31:2], 2'b00};
    assign xfer       = MemWriteValid && MemWriteReady;
    assign final_beat = (state == BEAT1) || ((state == BEAT0) && !split_r);
    // Only combinational path from MemWriteReady: lets aligned stores stream.
    assign StoreReady = (state == IDLE) || (final_beat && MemWriteReady);
    assign accept     = StoreValid && StoreReady;
    assign drop       = illegal || (split && !SPLIT_MISALIGNED);
    assign Busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            MemWriteValid <= 1'b0;
            MemAddr       <= '0;
            MemWriteData  <= '0;
            MemByteEn     <= '0;
            StoreErr      <= 1'b0;
            beat1_addr    <= '0;
            beat1_data    <= '0;
            beat1_be      <= '0;
            split_r       <= 1'b0;
        end else begin
            StoreErr <= 1'b0;
            if ((state == BEAT0) && xfer && split_r) begin
                state        <= BEAT1;
                MemAddr      <= beat1_addr;
                MemWriteData <= beat1_data;
                MemByteEn    <= beat1_be;
            end else if (accept && drop) begin
                state         <= IDLE;
                MemWriteValid <= 1'b0;
                StoreErr      <= 1'b1;
            end else if (accept) begin
                state         <= BEAT0;
                MemWriteValid <= 1'b1;
                MemAddr       <= word_addr;
                MemWriteData  <= d64[31:0];
                MemByteEn     <= be8[3:0];
                beat1_addr    <= word_addr + 32'd4;
                beat1_data    <= d64[63:32];
                beat1_be      <= be8[7:4];
                split_r       <= split;
            end else if (xfer) begin
                state         <= IDLE;
                MemWriteValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: directed and random stores against a byte-address
// reference model, with a queue-based scoreboard and a second non-splitting instance.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StoreValid = 1'b0;
    logic        StoreReady;
    logic [31:0] StoreAddr = '0;
    logic [31:0] StoreData = '0;
    logic [2:0]  WidthSrc = '0;
    logic        MemWriteValid;
    logic        MemWriteReady = 1'b0;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic [3:0]  MemByteEn;
    logic        StoreErr;
    logic        Busy;

    logic        ns_store_valid = 1'b0;
    logic        ns_store_ready;
    logic [31:0] ns_store_addr = '0;
    logic [31:0] ns_store_data = '0;
    logic [2:0]  ns_width = '0;
    logic        ns_mem_valid;
    logic        ns_mem_ready = 1'b1;
    logic [31:0] ns_mem_addr;
    logic [31:0] ns_mem_data;
    logic [3:0]  ns_mem_be;
    logic        ns_store_err;
    logic        ns_busy;

    int          checks = 0;
    int          errors = 0;
    logic [67:0] exp_q[$];
    int          err_pending = 0;
    int          rdy_mode = 1;
    int          rdy_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [67:0] held;
    logic [67:0] cur;
    logic [67:0] exp_beat;

    store_align_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .StoreValid(StoreValid), .StoreReady(StoreReady),
        .StoreAddr(StoreAddr), .StoreData(StoreData), .WidthSrc(WidthSrc),
        .MemWriteValid(MemWriteValid), .MemWriteReady(MemWriteReady),
        .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemByteEn(MemByteEn),
        .StoreErr(StoreErr), .Busy(Busy)
    );

    store_align_unit #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .reset(reset),
        .StoreValid(ns_store_valid), .StoreReady(ns_store_ready),
        .StoreAddr(ns_store_addr), .StoreData(ns_store_data), .WidthSrc(ns_width),
        .MemWriteValid(ns_mem_valid), .MemWriteReady(ns_mem_ready),
        .MemAddr(ns_mem_addr), .MemWriteData(ns_mem_data), .MemByteEn(ns_mem_be),
        .StoreErr(ns_store_err), .Busy(ns_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Memory-side ready: 0 = always, 1 = random, 2 = never, 3 = three low then one high.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       MemWriteReady = 1'b1;
            1:       MemWriteReady = ($urandom_range(0, 3) != 0);
            2:       MemWriteReady = 1'b0;
            default: begin
                MemWriteReady = ((rdy_cnt % 4) == 3);
                rdy_cnt++;
            end
        endcase
    end

    task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each of the four data bytes goes to byte address addr+k; bytes whose word
    // differs from the first word land in the second beat. Only the first
    // width-many bytes get enables.
    task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
        int          n;
        int          lane;
        logic [31:0] base;
        logic [31:0] ba;
        logic [31:0] dat0, dat1;
        logic [3:0]  be0, be1;
        bit          two;
        case (w)
            3'b000:         n = 4;
            3'b010, 3'b110: n = 2;
            3'b001, 3'b101: n = 1;
            default:        n = 0;
        endcase
        if (n == 0) begin
            err_pending++;
            return;
        end
        base = a & ~32'h3;
        dat0 = '0; dat1 = '0; be0 = '0; be1 = '0; two = 0;
        for (int k = 0; k < 4; k++) begin
            ba   = a + k;
            lane = int'(ba[1:0]);
            if ((ba & ~32'h3) == base) begin
                dat0[lane*8 +: 8] = d[k*8 +: 8];
                if (k < n) be0[lane] = 1'b1;
            end else begin
                dat1[lane*8 +: 8] = d[k*8 +: 8];
                if (k < n) begin
                    be1[lane] = 1'b1;
                    two = 1;
                end
            end
        end
        exp_q.push_back({base, dat0, be0});
        if (two) exp_q.push_back({base + 32'd4, dat1, be1});
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w,
                         output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        @(negedge clk);
        StoreValid = 1'b1;
        StoreAddr  = a;
        StoreData  = d;
        WidthSrc   = w;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (StoreReady) begin
                ok = 1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got StoreReady=0 expected 1 within 200 cycles");
            StoreValid = 1'b0;
            return;
        end
        model_push(a, d, w);
        @(posedge clk);
        #1 StoreValid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && err_pending == 0 && !Busy) break;
        end
        check("drain_beats", 68'(exp_q.size()), 68'(0));
        check("drain_errs", 68'(err_pending), 68'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 68'(MemWriteValid), 68'(0));
        check({tag, "_addr"}, 68'(MemAddr), 68'(0));
        check({tag, "_data"}, 68'(MemWriteData), 68'(0));
        check({tag, "_be"}, 68'(MemByteEn), 68'(0));
        check({tag, "_err"}, 68'(StoreErr), 68'(0));
        check({tag, "_busy"}, 68'(Busy), 68'(0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            cur = {MemAddr, MemWriteData, MemByteEn};
            if (stall_prev) begin
                check("stall_valid_held", 68'(MemWriteValid), 68'(1));
                check("stall_beat_held", cur, held);
            end
            if (MemWriteValid && !MemWriteReady) begin
                check("stall_store_ready", 68'(StoreReady), 68'(0));
                stall_prev = 1'b1;
                held = cur;
            end else begin
                stall_prev = 1'b0;
            end
            if (MemWriteValid && MemWriteReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", cur);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat_addr", 68'(MemAddr), 68'(exp_beat[67:36]));
                    check("beat_data", 68'(MemWriteData), 68'(exp_beat[35:4]));
                    check("beat_be", 68'(MemByteEn), 68'(exp_beat[3:0]));
                end
            end
            if (StoreErr) begin
                checks++;
                if (err_pending == 0) begin
                    errors++;
                    $display("FAIL unexpected_store_err: got 1 expected 0");
                end else begin
                    err_pending--;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          waited;
        int          total_wait;
        logic [31:0] a;
        logic [2:0]  w;
        bit          seen;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_ready", 68'(StoreReady), 68'(1));

        // Non-splitting instance: a crossing word is dropped, an aligned word goes out.
        @(negedge clk);
        ns_store_valid = 1'b1; ns_store_addr = 32'h5002; ns_store_data = 32'h12345678; ns_width = 3'b000;
        #1 check("ns_ready", 68'(ns_store_ready), 68'(1));
        @(posedge clk);
        #1 ns_store_valid = 1'b0;
        @(negedge clk);
        check("ns_err_pulse", 68'(ns_store_err), 68'(1));
        check("ns_no_beat", 68'(ns_mem_valid), 68'(0));
        ns_store_valid = 1'b1; ns_store_addr = 32'h5004; ns_store_data = 32'hA1B2C3D4;
        @(posedge clk);
        #1 ns_store_valid = 1'b0;
        @(negedge clk);
        check("ns_err_single", 68'(ns_store_err), 68'(0));
        check("ns_beat_valid", 68'(ns_mem_valid), 68'(1));
        check("ns_beat_addr", 68'(ns_mem_addr), 68'(32'h5004));
        check("ns_beat_data", 68'(ns_mem_data), 68'(32'hA1B2C3D4));
        check("ns_beat_be", 68'(ns_mem_be), 68'(4'b1111));
        @(negedge clk);
        check("ns_idle_after", 68'(ns_mem_valid), 68'(0));

        // Directed cases.
        issue(32'h0000_1000, 32'hDEADBEEF, 3'b000, waited);
        issue(32'h0000_2003, 32'h0000_00A5, 3'b001, waited);
        issue(32'h0000_2003, 32'h0000_00A5, 3'b101, waited);
        issue(32'h0000_3003, 32'h0000_BEEF, 3'b010, waited);
        issue(32'h0000_3001, 32'h0000_CAFE, 3'b110, waited);
        issue(32'h0000_1234, 32'h0000_0000, 3'b011, waited);
        issue(32'hFFFF_FFFE, 32'h8899AABB, 3'b000, waited);
        drain();

        rdy_mode = 3;
        issue(32'h0000_4001, 32'h11223344, 3'b000, waited);
        drain();

        // Streaming aligned words with the memory always ready.
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        total_wait = 0;
        for (int i = 0; i < 8; i++) begin
            issue(32'h0000_0100 + 32'(i * 4), $urandom, 3'b000, waited);
            total_wait += waited;
        end
        check("back_to_back_waits", 68'(total_wait), 68'(0));
        drain();

        // Random traffic with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            w = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(a, $urandom, w, waited);
        end
        drain();

        // Reset while the first beat of a split store is stalled.
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        issue(32'h0000_6003, 32'hCAFEF00D, 3'b010, waited);
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (MemWriteValid) begin
                seen = 1;
                break;
            end
        end
        check("midop_beat0_present", 68'(seen), 68'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_idle_outputs("midop_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        rdy_mode = 1;
        repeat (20) @(negedge clk);
        check("midop_no_beat1", 68'(MemWriteValid), 68'(0));
        check("midop_idle", 68'(Busy), 68'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached expected test completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Store-side counterpart to the load width-reduction path. Accepts a store request (address, register data, width code) from the MEM stage.
- Shifts the data into the correct byte lanes and generates byte enables.
- Issues one or two word-aligned write beats to the data memory port over a valid/ready handshake.
- Stores that cross a word boundary are split into two beats; illegal width codes are flagged and dropped.

Parameters:
- SPLIT_MISALIGNED, 1. 1 = split boundary-crossing stores into two beats; 0 = report them on StoreErr and drop them.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- StoreValid  input  1  store request present
- StoreReady  output  1  unit can accept a request this cycle
- StoreAddr  input  32  byte address of the store
- StoreData  input  32  rs2 data; the value is taken from its low-order bytes
- WidthSrc  input  3  width code: 000 word, 010 half, 001 byte; 110/101 are accepted as half/byte (signedness is irrelevant for stores); all other codes are illegal
- MemWriteValid  output  1  write beat valid
- MemWriteReady  input  1  memory accepts the beat
- MemAddr  output  32  word-aligned beat address (bits [1:0] = 00)
- MemWriteData  output  32  lane-aligned write data
- MemByteEn  output  4  byte enables; bit i enables MemWriteData[8i+7:8i]
- StoreErr  output  1  one-cycle pulse for a dropped request
- Busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE; MemWriteValid=0, MemAddr=0, MemWriteData=0, MemByteEn=0, StoreErr=0.
  - Reset mid-operation abandons any pending beat; beat 1 of a split store is never issued.
- Handshakes:
  - Request is accepted on StoreValid && StoreReady.
  - A beat transfers on MemWriteValid && MemWriteReady.
  - While a beat is presented, MemAddr, MemWriteData and MemByteEn are held stable until it transfers.
- Lane math at acceptance (off = StoreAddr[1:0]):
  - mask = 0001 (byte), 0011 (half), 1111 (word).
  - be8 = {4'b0,mask} << off.
  - d64 = {32'b0,StoreData} << 8*off.
  - split = (be8[7:4] != 0).
- Beat contents:
  - Beat 0: MemAddr = {StoreAddr[31:2],2'b00}, MemWriteData = d64[31:0], MemByteEn = be8[3:0].
  - Beat 1: MemAddr = beat-0 address + 4 (32-bit wrap: 0xFFFFFFFC becomes 0x00000000), MemWriteData = d64[63:32], MemByteEn = be8[7:4].
  - Beat-1 fields are stored in registers at acceptance.
- FSM:
  - IDLE: StoreReady=1. On acceptance, load the beat-0 registers and go to BEAT0. Exception: illegal width, or split with SPLIT_MISALIGNED=0, sets StoreErr=1 for the next cycle and stays in IDLE.
  - BEAT0: MemWriteValid=1. On transfer: if split, go to BEAT1; otherwise go to IDLE or directly accept a new request.
  - BEAT1: MemWriteValid=1. On transfer, go to IDLE or directly accept a new request.
- Back-to-back:
  - StoreReady = IDLE || (final beat && MemWriteReady). This is the only combinational path from MemWriteReady.
  - Aligned stores sustain one per cycle with MemWriteReady held high.
- Latency: the first beat is valid in the cycle after acceptance (registered outputs).
- StoreErr: asserted exactly one cycle per dropped request. A dropped request never raises MemWriteValid.
- Simultaneous events:
  - An erroring request accepted on a final-beat transfer leaves MemWriteValid=0 next cycle and raises StoreErr.
  - StoreValid while not ready: the request is held by the upstream stage and is not sampled.

Decomposition:
- Shared package (riscv_pkg or the existing equivalent) holds:
  - width-code localparams WIDTH_WORD=3'b000, WIDTH_HALF=3'b010, WIDTH_HALFU=3'b110, WIDTH_BYTE=3'b001, WIDTH_BYTEU=3'b101, also used by the load reduce path;
  - the FSM state enum typedef {IDLE, BEAT0, BEAT1}.
- One sub-module: store_lane_shift. It is combinational: StoreAddr[1:0] and WidthSrc in; d64, be8, split and illegal out. It gets its own unit bench.

Test Plan:
- Aligned word: addr 0x1000, data 0xDEADBEEF, WidthSrc 000, ready=1 -> one beat: 0x1000 / 0xDEADBEEF / 1111; next request accepted in the same cycle as that beat transfers.
- Byte lanes: addr 0x2003, data 0x000000A5, WidthSrc 001 -> MemAddr 0x2000, data 0xA5000000, ByteEn 1000. Repeat with WidthSrc 101 -> identical output.
- Split half: addr 0x3003, data 0x0000BEEF, 010 -> beat 0x3000 / 0xEF000000 / 1000, then 0x3004 / 0x000000BE / 0001.
- Split word with backpressure: addr 0x4001, data 0x11223344, MemWriteReady low 3 cycles each beat -> beat 0x4000 / 0x22334400 / 1110, then 0x4004 / 0x00000011 / 0001; outputs stable while stalled; StoreReady=0 throughout.
- Errors: WidthSrc 011 -> StoreErr pulses 1 cycle, no beat issued. SPLIT_MISALIGNED=0 with a word at 0x5002 -> StoreErr, no beat issued.
- Wrap and reset: word at 0xFFFFFFFE -> beats 0xFFFFFFFC then 0x00000000. Assert reset during BEAT0 of a split store -> all outputs 0, no beat 1 issued.
